edge_det_bank: RTL and testbench
================================

Name: edge_det_bank

Overview:
Parametrised multi-channel edge (flank) detector. It is the successor to the single toggle-on-change flank detector.
- Each channel synchronises an asynchronous input and detects rising, falling or both edges, selected per channel.
- Per channel it produces a one-cycle pulse, a toggle output, a sticky flag and a saturating event counter.
- Sits between raw external lines (buttons, sensor strobes) and control logic or a status register block.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
CNT_W, 8, width of each per-channel event counter (>=1)

Ports:
clk  input  1  single system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
din  input  CHANNELS  raw asynchronous inputs, bit i = channel i
mode  input  2*CHANNELS  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
clr  input  1  synchronous clear of sticky flags and counters, all channels
pulse  output  CHANNELS  one-cycle detection pulse per channel
toggle  output  CHANNELS  inverts on every detected edge
sticky  output  CHANNELS  set on detection, held until clr
count  output  CHANNELS*CNT_W  per-channel saturating event count, channel i at [i*CNT_W +: CNT_W]
any_event  output  1  OR of all pulse bits, registered with pulse

Behaviour:
- Reset (rst_n low, asynchronous): all synchroniser flops, prev samples, pulse, toggle, sticky, count and any_event are 0. The warm-up counter is cleared.
- Synchroniser: s[0] <= din, s[k] <= s[k-1]. The synchronised value is s[SYNC_STAGES-1].
- Prev register: prev <= s[SYNC_STAGES-1] every cycle, including during warm-up.
- Raw edge terms: rise = s_last & ~prev; fall = ~s_last & prev.
- Per-channel detection:
  - det = (mode[0] & rise) | (mode[1] & fall).
  - Mode 00 never detects.
  - Mode is sampled combinationally at the detection edge. A mode change produces no spurious event.
- Warm-up:
  - After rst_n deasserts, detection is gated off for the first SYNC_STAGES+1 rising edges.
  - An input held high through reset therefore yields no rising event.
- Latency: din changes and is stable before clock edge N. pulse is high from edge N+SYNC_STAGES to edge N+SYNC_STAGES+1, exactly one cycle. toggle, sticky and count update at the same edge as pulse.
- pulse is registered: pulse <= det. any_event <= |det.
- toggle: toggle <= toggle ^ det. clr does not affect toggle.
- sticky:
  - sticky <= (sticky & ~clr) | det.
  - clr and det in the same cycle leaves sticky = 1 (event wins).
- count:
  - If clr: count <= det ? 1 : 0.
  - Else if det and count != all-ones: count <= count+1.
  - At all-ones the count holds (saturates, no wrap).
- Consecutive edges: an input toggling every cycle (after sync) in mode 11 gives pulse high continuously, and count increments every cycle until it saturates.
- Glitches shorter than one clock period may be missed. This is acceptable and is not an error.
- Channels are fully independent. Simultaneous events on several channels are each counted.
- Reset mid-operation: immediate asynchronous return to reset state. Warm-up restarts on release.

Decomposition:
- Package edge_det_pkg:
  - mode constants: MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11.
  - a localparam for the warm-up counter width: $clog2(SYNC_STAGES+2).
- Sub-module edge_det_chan (one channel: synchroniser, prev, det, pulse/toggle/sticky/count). Ports: clk, rst_n, din, mode, clr, en, pulse, toggle, sticky, count.
- Top edge_det_bank:
  - instantiates CHANNELS copies in a generate loop;
  - owns the shared warm-up counter that drives en;
  - computes any_event.

Test Plan:
- Reset and warm-up: din=4'b1111 through reset, release rst_n, all modes 11. Required: no pulse, count=0 and sticky=0 for 10 cycles.
- Rising-only latency: ch0 mode 01, SYNC_STAGES=2, din[0] 0->1 before edge N then back to 0 after 5 cycles. Required: pulse[0] high exactly during cycle N+2..N+3 only, count0=1, toggle[0]=1, sticky[0]=1. No pulse on the falling edge.
- Both-edge mode and toggle: ch1 mode 11, three full pulses on din[1]. Required: six one-cycle pulses, count1=6, toggle[1]=0, any_event high in each of those cycles.
- Saturation with CNT_W=3: ch2 mode 01, 10 rising edges. Required: count2 reaches 7 and holds at 7.
- clr collision: ch3 count=5, sticky=1. Assert clr in the same cycle as a detected edge. Required: count3=1, sticky[3]=1. A clr with no edge next gives count3=0, sticky[3]=0, and toggle unchanged.
- Mode off and async reset mid-run: ch0 mode 00 with edges gives no pulse and count stays 0. Pull rst_n low mid-burst. Required: all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/edge_det_pkg.sv
// edge_det_pkg: shared definitions for the multi-channel edge detector.
//   MODE_*      per-channel detection mode encodings (2 bits per channel)
//   warm_width  width of the warm-up counter for a given synchroniser depth
package edge_det_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Warm-up counter width for the default depth; modules with a different
  // depth derive theirs through warm_width().
  localparam int SYNC_STAGES_DEF = 2;
  localparam int WARM_W          = $clog2(SYNC_STAGES_DEF + 2);

  // The counter has to reach SYNC_STAGES+1, hence +2 inside $clog2.
  function automatic int warm_width(input int sync_stages);
    return $clog2(sync_stages + 2);
  endfunction

endpackage

// File: rtl/edge_det_chan.sv
// edge_det_chan: one channel of the edge detector bank.
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : raw asynchronous input line
//   mode       : 00 off, 01 rising, 10 falling, 11 both
//   clr        : synchronous clear of sticky and count
//   en         : detection enable (low during post-reset warm-up)
//   pulse      : one-cycle registered detection pulse
//   toggle     : inverts on every detected edge
//   sticky     : set on detection, held until clr
//   count      : saturating event counter
module edge_det_chan
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic [1:0]       mode,
  input  logic             clr,
  input  logic             en,
  output logic             pulse,
  output logic             toggle,
  output logic             sticky,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   s_last;
  logic                   rise;
  logic                   fall;
  logic                   want_rise;
  logic                   want_fall;
  logic                   det;

  assign s_last = sync_q[SYNC_STAGES-1];
  assign rise   = s_last & ~prev_q;
  assign fall   = ~s_last & prev_q;

  // Mode is decoded combinationally: changing it only changes which of the
  // raw edge terms is honoured, it can never create an edge by itself.
  assign want_rise = (mode == MODE_RISE) || (mode == MODE_BOTH);
  assign want_fall = (mode == MODE_FALL) || (mode == MODE_BOTH);
  assign det       = en & ((want_rise & rise) | (want_fall & fall));

  // Synchroniser and prev keep running during warm-up so that a level held
  // through reset is already in prev once detection is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= s_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse  <= 1'b0;
      toggle <= 1'b0;
      sticky <= 1'b0;
      count  <= '0;
    end else begin
      pulse  <= det;
      toggle <= toggle ^ det;
      // An event in the same cycle as clr survives the clear.
      sticky <= (sticky & ~clr) | det;
      if (clr) begin
        count <= det ? CNT_ONE : '0;
      end else if (det && (count != CNT_MAX)) begin
        count <= count + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/edge_det_bank.sv
// edge_det_bank: parametrised multi-channel edge detector.
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : raw asynchronous inputs, bit i = channel i
//   mode       : per-channel mode at [2i+1:2i] (00 off/01 rise/10 fall/11 both)
//   clr        : synchronous clear of sticky flags and counters
//   pulse      : one-cycle detection pulse per channel
//   toggle     : per-channel toggle on each detected edge
//   sticky     : per-channel sticky detection flag
//   count      : per-channel saturating count at [i*CNT_W +: CNT_W]
//   any_event  : OR of all pulse bits
module edge_det_bank
  import edge_det_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       din,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic                      clr,
  output logic [CHANNELS-1:0]       pulse,
  output logic [CHANNELS-1:0]       toggle,
  output logic [CHANNELS-1:0]       sticky,
  output logic [CHANNELS*CNT_W-1:0] count,
  output logic                      any_event
);

  localparam int              WW        = warm_width(SYNC_STAGES);
  localparam logic [WW-1:0]   WARM_DONE = WW'(SYNC_STAGES + 1);

  logic [WW-1:0] warm_q;
  logic          en;

  // Detection is held off for the first SYNC_STAGES+1 edges after reset:
  // the synchroniser needs SYNC_STAGES edges to fill and prev one more, so
  // a line held high through reset never looks like a rising edge.
  assign en = (warm_q == WARM_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_q <= '0;
    end else if (!en) begin
      warm_q <= warm_q + WW'(1);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    edge_det_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (din[i]),
      .mode   (mode[2*i +: 2]),
      .clr    (clr),
      .en     (en),
      .pulse  (pulse[i]),
      .toggle (toggle[i]),
      .sticky (sticky[i]),
      .count  (count[i*CNT_W +: CNT_W])
    );
  end

  // pulse is already a register of det, so ORing the pulse flops gives the
  // same cycle-exact value as registering |det, without a separate flop.
  assign any_event = |pulse;

endmodule

// File: tb/tb_edge_det_bank.sv
// tb_edge_det_bank: directed self-checking bench for edge_det_bank
// (CHANNELS=4, SYNC_STAGES=2, CNT_W=3).
module tb_edge_det_bank;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int CW = 3;

  logic             clk;
  logic             rst_n;
  logic [CH-1:0]    din;
  logic [2*CH-1:0]  mode;
  logic             clr;
  logic [CH-1:0]    pulse;
  logic [CH-1:0]    toggle;
  logic [CH-1:0]    sticky;
  logic [CH*CW-1:0] count;
  logic             any_event;

  int n_cmp = 0;
  int n_err = 0;

  logic [CH-1:0] exp_q[$];

  edge_det_bank #(
    .CHANNELS    (CH),
    .SYNC_STAGES (SS),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .mode      (mode),
    .clr       (clr),
    .pulse     (pulse),
    .toggle    (toggle),
    .sticky    (sticky),
    .count     (count),
    .any_event (any_event)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // driver helpers: inputs change and outputs are sampled 1ns after posedge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] cnt(input int ch);
    return count[ch*CW +: CW];
  endfunction

  initial begin
    logic [CH-1:0] e;

    // Reset with all inputs high and all modes both-edge
    rst_n = 1'b0;
    din   = '1;
    mode  = '1;
    clr   = 1'b0;
    repeat (3) step();
    check("rst_pulse",  pulse,     0);
    check("rst_toggle", toggle,    0);
    check("rst_sticky", sticky,    0);
    check("rst_count",  count,     0);
    check("rst_any",    any_event, 0);

    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("warm_pulse", pulse,     0);
      check("warm_any",   any_event, 0);
    end
    check("warm_count",  count,  0);
    check("warm_sticky", sticky, 0);
    check("warm_toggle", toggle, 0);

    // Rising-only latency on ch0
    mode = '0;
    din  = '0;
    repeat (4) step();
    mode   = 8'b00_00_00_01;
    din[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("rise_pulse0", pulse[0], (k == 2) ? 1 : 0);
      check("rise_any",    any_event, (k == 2) ? 1 : 0);
    end
    step();
    din[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check("rise_nofall", pulse[0], 0);
    end
    check("rise_count0",  cnt(0),    1);
    check("rise_toggle0", toggle[0], 1);
    check("rise_sticky0", sticky[0], 1);

    // Both-edge mode on ch1: three full pulses -> six detections
    mode = 8'b00_00_11_01;
    for (int k = 0; k < 22; k++)
      exp_q.push_back((k >= 2 && k <= 17 && ((k - 2) % 3) == 0) ? 4'b0010 : 4'b0000);
    for (int k = 0; k < 22; k++) begin
      din[1] = (k < 18) && (((k / 3) % 2) == 0);
      step();
      e = exp_q.pop_front();
      check("both_pulse", pulse,     e);
      check("both_any",   any_event, |e);
    end
    check("both_count1",  cnt(1),    6);
    check("both_toggle1", toggle[1], 0);
    check("both_sticky1", sticky[1], 1);

    // Saturation on ch2 (3-bit counter): ten rising edges
    mode = 8'b00_01_11_01;
    for (int k = 0; k < 20; k++) begin
      din[2] = ((k % 2) == 0);
      step();
      if (k == 13) check("sat_count2_6", cnt(2), 6);
      if (k == 14) check("sat_count2_7", cnt(2), 7);
    end
    repeat (3) step();
    check("sat_count2_hold", cnt(2),    7);
    check("sat_sticky2",     sticky[2], 1);
    check("sat_toggle2",     toggle[2], 0);

    // Consecutive edges on ch3 in both-edge mode: continuous pulse
    mode = 8'b11_01_11_01;
    for (int k = 0; k < 9; k++) begin
      din[3] = (k < 5) ? ((k % 2) == 0) : 1'b1;
      step();
      check("consec_pulse3", pulse[3], (k >= 2 && k <= 6) ? 1 : 0);
    end
    check("consec_count3",  cnt(3),    5);
    check("consec_toggle3", toggle[3], 1);
    check("consec_sticky3", sticky[3], 1);

    // clr colliding with a falling edge on ch3
    for (int k = 0; k < 3; k++) begin
      if (k == 0) din[3] = 1'b0;
      if (k == 2) clr = 1'b1;
      step();
    end
    clr = 1'b0;
    check("clr_hit_pulse3",  pulse[3],  1);
    check("clr_hit_count3",  cnt(3),    1);
    check("clr_hit_sticky3", sticky[3], 1);
    check("clr_hit_toggle3", toggle[3], 0);
    check("clr_hit_count2",  cnt(2),    0);
    check("clr_hit_sticky2", sticky[2], 0);
    check("clr_hit_count1",  cnt(1),    0);

    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_only_count",  count,  0);
    check("clr_only_sticky", sticky, 0);
    check("clr_only_toggle", toggle, 4'b0001);

    // Mode off on ch0: edges must be ignored
    mode = 8'b11_01_11_00;
    for (int k = 0; k < 8; k++) begin
      din[0] = ((k % 2) == 0);
      step();
      check("off_pulse0", pulse[0], 0);
    end
    repeat (3) step();
    check("off_count0",  cnt(0),    0);
    check("off_sticky0", sticky[0], 0);

    // Burst on ch1, then asynchronous reset between clock edges
    for (int k = 0; k < 6; k++) begin
      din[1] = ((k % 2) == 0);
      step();
    end
    check("burst_pulse1", pulse[1], 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pulse",  pulse,     0);
    check("arst_toggle", toggle,    0);
    check("arst_sticky", sticky,    0);
    check("arst_count",  count,     0);
    check("arst_any",    any_event, 0);

    step();
    rst_n = 1'b1;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
